// File: rtl/word_narrow_unit_pkg.sv
// Shared definitions for the word narrowing unit.
// Holds the FSM state encoding, the mode constants carried on in_split, and
// the default byte/word widths used by the top level and the fit checker.
package word_narrow_unit_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  // IDLE: nothing held; EMIT0: first (or only) byte on the output;
  // EMIT1: second byte of a SPLIT word on the output.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_EMIT0 = 2'b01,
    ST_EMIT1 = 2'b10
  } state_e;

  localparam logic MODE_NARROW = 1'b0;
  localparam logic MODE_SPLIT  = 1'b1;

endpackage

// File: rtl/word_narrow_unit_fit_check.sv
// narrow_fit_check: combinational test of whether a word is the sign
// extension of its low OUT_W bits, i.e. narrowing it loses nothing.
// Ports:
//   word  in  IN_W  word under test
//   fits  out 1     1 when word[IN_W-1:OUT_W] replicates word[OUT_W-1]
module narrow_fit_check #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0] word,
  output logic            fits
);

  assign fits = (word[IN_W-1:OUT_W] == {(IN_W-OUT_W){word[OUT_W-1]}});

endmodule

// File: rtl/word_narrow_unit.sv
// word_narrow_unit: narrows stack words to bytes for a byte-wide sink.
// NARROW emits the low byte with an overflow flag; SPLIT emits both bytes
// over two output transfers. valid/ready handshakes on both sides, all
// outputs registered.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          input handshake
//   in_word [IN_W]             word to narrow
//   in_split                   1 = SPLIT, 0 = NARROW
//   out_valid/out_ready        output handshake
//   out_byte [OUT_W]           emitted byte
//   out_last                   final byte of the current word
//   out_ovf                    NARROW word did not fit in a signed byte
//   ovf_count [8]              saturating count of overflowed NARROW words
module word_narrow_unit
  import word_narrow_unit_pkg::*;
#(
  parameter int IN_W      = WORD_W,
  parameter int OUT_W     = BYTE_W,
  parameter bit LOW_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_word,
  input  logic             in_split,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_byte,
  output logic             out_last,
  output logic             out_ovf,
  output logic [7:0]       ovf_count
);

  state_e           r_state;
  logic [IN_W-1:0]  r_word;
  logic             r_split;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_byte;
  logic             r_out_last;
  logic             r_out_ovf;
  logic [7:0]       r_ovf_count;

  logic             w_fits;
  logic             w_out_xfer;
  logic             w_in_ready;
  logic             w_accept;
  logic [OUT_W-1:0] w_first_byte;
  logic [OUT_W-1:0] w_second_byte;

  narrow_fit_check #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_fit_check (
    .word (in_word),
    .fits (w_fits)
  );

  assign w_out_xfer = r_out_valid && out_ready;
  // A new word may load in the same cycle the last byte of the old one leaves.
  assign w_in_ready = (r_state == ST_IDLE) || (w_out_xfer && r_out_last);
  assign w_accept   = in_valid && w_in_ready;

  // First byte is the low byte for NARROW; for SPLIT it depends on LOW_FIRST.
  assign w_first_byte = (in_split == MODE_SPLIT)
                      ? (LOW_FIRST ? in_word[OUT_W-1:0] : in_word[IN_W-1:OUT_W])
                      : in_word[OUT_W-1:0];
  assign w_second_byte = LOW_FIRST ? r_word[IN_W-1:OUT_W] : r_word[OUT_W-1:0];

  // FSM, held word and output register; an accept takes priority since it
  // can only coincide with the transfer of a last byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_word      <= '0;
      r_split     <= MODE_NARROW;
      r_out_valid <= 1'b0;
      r_out_byte  <= '0;
      r_out_last  <= 1'b0;
      r_out_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_state     <= ST_EMIT0;
      r_word      <= in_word;
      r_split     <= in_split;
      r_out_valid <= 1'b1;
      r_out_byte  <= w_first_byte;
      r_out_last  <= (in_split != MODE_SPLIT);
      r_out_ovf   <= (in_split != MODE_SPLIT) && !w_fits;
    end else if (w_out_xfer) begin
      case (r_state)
        ST_EMIT0: begin
          if (r_split == MODE_SPLIT) begin
            r_state    <= ST_EMIT1;
            r_out_byte <= w_second_byte;
            r_out_last <= 1'b1;
            r_out_ovf  <= 1'b0;
          end else begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        ST_EMIT1: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Overflow counter: counts on the output transfer of a flagged byte, sticks at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_count <= 8'd0;
    end else if (w_out_xfer && r_out_ovf && (r_ovf_count != 8'hFF)) begin
      r_ovf_count <= r_ovf_count + 8'd1;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_byte  = r_out_byte;
  assign out_last  = r_out_last;
  assign out_ovf   = r_out_ovf;
  assign ovf_count = r_ovf_count;

endmodule

// File: tb/tb_word_narrow_unit.sv
// Self-checking bench for word_narrow_unit (LOW_FIRST = 0): directed vector
// table, hand-written multi-cycle sequences, then randomized traffic checked
// against a byte-queue reference model.
module tb_word_narrow_unit;

  localparam bit LOW_FIRST = 1'b0;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_word;
  logic        in_split;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;
  logic        out_ovf;
  logic [7:0]  ovf_count;

  int n_checks;
  int n_fail;
  int exp_cnt;

  typedef struct {
    logic [15:0] word;
    logic        split;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [7:0] b;
    logic       last;
    logic       ovf;
  } exp_t;

  vec_t vecs[8];
  exp_t q[$];

  word_narrow_unit #(
    .IN_W      (16),
    .OUT_W     (8),
    .LOW_FIRST (LOW_FIRST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .in_split  (in_split),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_last  (out_last),
    .out_ovf   (out_ovf),
    .ovf_count (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Reference: push the bytes a word should produce, from the word's value.
  task automatic model_push(input logic [15:0] w, input logic sp);
    int   sv;
    exp_t e;
    if (sp) begin
      e.b = LOW_FIRST ? w[7:0] : w[15:8]; e.last = 1'b0; e.ovf = 1'b0; q.push_back(e);
      e.b = LOW_FIRST ? w[15:8] : w[7:0]; e.last = 1'b1; e.ovf = 1'b0; q.push_back(e);
    end else begin
      sv = $signed(w);
      e.b = w[7:0]; e.last = 1'b1; e.ovf = (sv < -128) || (sv > 127); q.push_back(e);
    end
  endtask

  initial begin
    logic exp_rdy;
    logic [7:0] lb;
    n_checks = 0; n_fail = 0; exp_cnt = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_word = 16'h0000; in_split = 1'b0; out_ready = 1'b0;

    vecs[0] = '{16'h007F, 1'b0, 8'h7F, 8'h00, 1'b0};
    vecs[1] = '{16'hFF80, 1'b0, 8'h80, 8'h00, 1'b0};
    vecs[2] = '{16'h0080, 1'b0, 8'h80, 8'h00, 1'b1};
    vecs[3] = '{16'h0100, 1'b0, 8'h00, 8'h00, 1'b1};
    vecs[4] = '{16'hBEEF, 1'b1, 8'hBE, 8'hEF, 1'b0};
    vecs[5] = '{16'hFFFF, 1'b0, 8'hFF, 8'h00, 1'b0};
    vecs[6] = '{16'h8000, 1'b0, 8'h00, 8'h00, 1'b1};
    vecs[7] = '{16'h1234, 1'b1, 8'h12, 8'h34, 1'b0};

    // Reset state
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_byte", out_byte, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_ovf_count", ovf_count, 0);
    check("rst_in_ready", in_ready, 1);
    step(); step();
    rst_n = 1'b1;
    step();

    // Directed vector table, one word at a time with out_ready held high
    for (int i = 0; i < 8; i++) begin
      in_word = vecs[i].word; in_split = vecs[i].split; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      check("vec_in_ready_idle", in_ready, 1);
      step();
      in_valid = 1'b0;
      check("vec_valid0", out_valid, 1);
      check("vec_byte0", out_byte, vecs[i].b0);
      check("vec_last0", out_last, !vecs[i].split);
      check("vec_ovf0", out_ovf, vecs[i].ovf);
      if (vecs[i].split) begin
        check("vec_in_ready_mid", in_ready, 0);
        step();
        check("vec_byte1", out_byte, vecs[i].b1);
        check("vec_last1", out_last, 1);
        check("vec_ovf1", out_ovf, 0);
      end
      if (vecs[i].ovf && exp_cnt < 255) exp_cnt++;
      step();
      check("vec_valid_end", out_valid, 0);
      check("vec_ovf_count", ovf_count, exp_cnt);
    end

    // Back-to-back NARROW, one byte per cycle
    out_ready = 1'b1; in_split = 1'b0; in_valid = 1'b1; in_word = 16'h0001;
    step();
    check("b2b_byte01", out_byte, 8'h01);
    check("b2b_ready01", in_ready, 1);
    in_word = 16'h0002;
    step();
    check("b2b_byte02", out_byte, 8'h02);
    check("b2b_valid02", out_valid, 1);
    in_word = 16'h0003;
    step();
    check("b2b_byte03", out_byte, 8'h03);
    check("b2b_valid03", out_valid, 1);
    in_valid = 1'b0;
    step();
    check("b2b_valid_end", out_valid, 0);

    // Backpressure on a SPLIT word
    in_word = 16'h1234; in_split = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check("bp_byte_first", out_byte, 8'h12);
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_byte", out_byte, 8'h12);
      check("bp_hold_last", out_last, 0);
      check("bp_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    check("bp_byte_second", out_byte, 8'h34);
    check("bp_last_second", out_last, 1);
    step();
    check("bp_valid_end", out_valid, 0);

    // 300 overflowed NARROW words saturate the counter
    in_word = 16'h0080; in_split = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    repeat (300) step();
    in_valid = 1'b0;
    step(); step();
    exp_cnt = 255;
    check("sat_ovf_count", ovf_count, exp_cnt);

    // Reset in the middle of a SPLIT word
    in_word = 16'hABCD; in_split = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("mid_byte_first", out_byte, 8'hAB);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_byte", out_byte, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_count", ovf_count, 0);
    exp_cnt = 0;
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_idle_valid", out_valid, 0);
    in_word = 16'h0042; in_split = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("post_rst_byte", out_byte, 8'h42);
    check("post_rst_last", out_last, 1);
    check("post_rst_ovf", out_ovf, 0);
    step();
    check("post_rst_valid_end", out_valid, 0);

    // Randomized traffic against the byte-queue model
    for (int c = 0; c < 600; c++) begin
      step();
      check("rnd_out_valid", out_valid, (q.size() != 0));
      if (q.size() != 0) begin
        check("rnd_out_byte", out_byte, q[0].b);
        check("rnd_out_last", out_last, q[0].last);
        check("rnd_out_ovf", out_ovf, q[0].ovf);
      end
      check("rnd_ovf_count", ovf_count, exp_cnt);
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      in_split  = $urandom_range(1);
      if ($urandom_range(2) == 0) begin
        lb = 8'($urandom);
        in_word = {{8{lb[7]}}, lb};
      end else begin
        in_word = 16'($urandom);
      end
      #1;
      exp_rdy = (q.size() == 0) || ((q.size() == 1) && out_ready);
      check("rnd_in_ready", in_ready, exp_rdy);
      if ((q.size() != 0) && out_ready) begin
        if (q[0].ovf && exp_cnt < 255) exp_cnt++;
        void'(q.pop_front());
      end
      if (in_valid && exp_rdy) model_push(in_word, in_split);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
